// File: rtl/mem_store_forward_unit.sv
// Store-data forwarding for the MIPS memory stage: keeps a shadow copy of the
// previous instruction's write-back fields and steers load data or the ALU
// result onto the store-data path when the store's rt matches that producer.
module mem_store_forward_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exmem_regwrite,
  input  logic              exmem_memwrite,
  input  logic              exmem_memtoreg,
  input  logic [REG_W-1:0]  exmem_reg,
  input  logic [DATA_W-1:0] exmem_alu,
  input  logic [DATA_W-1:0] exmem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] store_data,
  output logic [1:0]        fwd_sel
);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;

  logic              wb_regwrite;
  logic              wb_memtoreg;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_ldata;
  logic              fwd_active;

  // Shadow of the instruction leaving EX/MEM; reset clears any pending forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_reg      <= '0;
      wb_alu      <= '0;
      wb_ldata    <= '0;
    end else begin
      wb_regwrite <= exmem_regwrite;
      wb_memtoreg <= exmem_memtoreg;
      wb_reg      <= exmem_reg;
      wb_alu      <= exmem_alu;
      wb_ldata    <= mem_rdata;
    end
  end

  // Forward only into a store whose rt is the previous instruction's nonzero destination.
  always_comb begin
    fwd_active = 1'b0;
    fwd_sel    = SEL_NONE;
    if (exmem_memwrite && wb_regwrite && (wb_reg != REG_W'(0)) && (wb_reg == exmem_reg)) begin
      fwd_active = 1'b1;
    end
    if (fwd_active) begin
      fwd_sel = wb_memtoreg ? SEL_LOAD : SEL_ALU;
    end
  end

  // 3:1 store-data mux; the unused 11 code falls back to the register-file value.
  always_comb begin
    store_data = exmem_wdata;
    unique case (fwd_sel)
      SEL_LOAD: store_data = wb_ldata;
      SEL_ALU:  store_data = wb_alu;
      default:  store_data = exmem_wdata;
    endcase
  end

endmodule

// File: tb/tb_mem_store_forward_unit.sv
// Bench for mem_store_forward_unit: table of per-cycle instructions with
// hand-derived expectations, routed through a scoreboard queue.
module tb_mem_store_forward_unit;

  logic        clk;
  logic        rst_n;
  logic        exmem_regwrite;
  logic        exmem_memwrite;
  logic        exmem_memtoreg;
  logic [4:0]  exmem_reg;
  logic [31:0] exmem_alu;
  logic [31:0] exmem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] store_data;
  logic [1:0]  fwd_sel;

  mem_store_forward_unit #(.DATA_W(32), .REG_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exmem_regwrite (exmem_regwrite),
    .exmem_memwrite (exmem_memwrite),
    .exmem_memtoreg (exmem_memtoreg),
    .exmem_reg      (exmem_reg),
    .exmem_alu      (exmem_alu),
    .exmem_wdata    (exmem_wdata),
    .mem_rdata      (mem_rdata),
    .store_data     (store_data),
    .fwd_sel        (fwd_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mw;
    logic        mtr;
    logic [4:0]  rg;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  sel;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [31:0] data;
  } exp_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic rw, input logic mw, input logic mtr,
                              input logic [4:0] rg, input logic [31:0] alu,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] sel, input logic [31:0] data);
    vec_t v;
    v.rw = rw; v.mw = mw; v.mtr = mtr; v.rg = rg; v.alu = alu;
    v.wdata = wdata; v.rdata = rdata; v.sel = sel; v.data = data;
    return v;
  endfunction

  task automatic drive(input logic rw, input logic mw, input logic mtr,
                       input logic [4:0] rg, input logic [31:0] alu,
                       input logic [31:0] wdata, input logic [31:0] rdata);
    exmem_regwrite = rw;
    exmem_memwrite = mw;
    exmem_memtoreg = mtr;
    exmem_reg      = rg;
    exmem_alu      = alu;
    exmem_wdata    = wdata;
    mem_rdata      = rdata;
  endtask

  task automatic expect_out(input string name, input logic [1:0] sel, input logic [31:0] data);
    exp_t e;
    e.name = name; e.sel = sel; e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: output observed with no expectation queued");
    end else begin
      e = sb.pop_front();
      checks++;
      if (fwd_sel !== e.sel) begin
        errors++;
        $display("FAIL %s fwd_sel: got %b expected %b", e.name, fwd_sel, e.sel);
      end
      checks++;
      if (store_data !== e.data) begin
        errors++;
        $display("FAIL %s store_data: got %h expected %h", e.name, store_data, e.data);
      end
    end
  endtask

  initial begin
    // rw mw mtr reg alu wdata rdata -> sel data
    vecs[0]  = mk(1, 0, 1, 5'h1C, 32'h0000_0100, 32'h0000_0000, 32'h0101_0100, 2'b00, 32'h0000_0000); // lw r28
    vecs[1]  = mk(0, 1, 0, 5'h1C, 32'h0000_0020, 32'h1234_5678, 32'hAAAA_0000, 2'b01, 32'h0101_0100); // sw r28 <- load
    vecs[2]  = mk(1, 0, 0, 5'h1C, 32'h0843_8433, 32'h0000_0055, 32'h0000_0077, 2'b00, 32'h0000_0055); // add r28
    vecs[3]  = mk(0, 1, 0, 5'h1C, 32'h0000_0019, 32'h0135_4440, 32'h0000_0000, 2'b10, 32'h0843_8433); // sw r28 <- alu
    vecs[4]  = mk(0, 1, 0, 5'h1C, 32'h0000_0030, 32'hCAFE_0001, 32'h0000_0000, 2'b00, 32'hCAFE_0001); // sw after sw
    vecs[5]  = mk(1, 0, 0, 5'h03, 32'h1111_1111, 32'h0000_0003, 32'h0000_0000, 2'b00, 32'h0000_0003); // add r3
    vecs[6]  = mk(0, 1, 0, 5'h1C, 32'h0000_0040, 32'h2222_0000, 32'h0000_0000, 2'b00, 32'h2222_0000); // sw r28, other reg
    vecs[7]  = mk(1, 0, 0, 5'h00, 32'hDEAD_BEEF, 32'h0000_0009, 32'h0000_0000, 2'b00, 32'h0000_0009); // add r0
    vecs[8]  = mk(0, 1, 0, 5'h00, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 2'b00, 32'h0000_0000); // sw r0
    vecs[9]  = mk(1, 0, 1, 5'h1C, 32'h0000_0048, 32'h0000_0004, 32'h0BAD_F00D, 2'b00, 32'h0000_0004); // lw r28
    vecs[10] = mk(1, 0, 0, 5'h1C, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 2'b00, 32'h0000_0006); // add r28 (non-store)
    vecs[11] = mk(0, 1, 0, 5'h1C, 32'h0000_0050, 32'h0000_0007, 32'h0000_0000, 2'b10, 32'h0000_0005); // sw r28 <- alu

    // Reset holds outputs at the un-forwarded value.
    rst_n = 1'b0;
    drive(0, 1, 0, 5'h1C, 32'h0, 32'h0101_0100, 32'h0);
    #2;
    expect_out("reset", 2'b00, 32'h0101_0100);
    check_out();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rw, vecs[i].mw, vecs[i].mtr, vecs[i].rg,
            vecs[i].alu, vecs[i].wdata, vecs[i].rdata);
      expect_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data);
      @(negedge clk);
      check_out();
    end

    // Mid-stream reset drops a pending forward immediately.
    @(posedge clk);
    #1;
    drive(1, 0, 1, 5'h1C, 32'h0, 32'h0, 32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    drive(0, 1, 0, 5'h1C, 32'h0, 32'h6666_0000, 32'h0);
    expect_out("pre_reset_fwd", 2'b01, 32'h5A5A_5A5A);
    #1;
    check_out();
    rst_n = 1'b0;
    #1;
    expect_out("mid_reset", 2'b00, 32'h6666_0000);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 1, 0, 5'h1C, 32'h0, 32'h7777_0000, 32'h0);
    expect_out("post_reset_store", 2'b00, 32'h7777_0000);
    @(negedge clk);
    check_out();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_store_forward_unit.md
# mem_store_forward_unit

Store-data forwarding unit for the MIPS memory stage. It sits between the EX/MEM pipeline register and the data-memory write port. It keeps a registered copy of the previous instruction's write-back information, detects when the store in EX/MEM needs a register value that instruction is about to write back, and drives the corrected store data to memory. It combines the forwarding decision logic and the 3:1 store-data multiplexer.

## Interface
Parameters:
- DATA_W, 32, datapath width (store data, ALU result, load data)
- REG_W, 5, register-specifier width

Ports:
- clk  in  1  rising-edge clock, shared with the pipeline registers
- rst_n  in  1  asynchronous, active-low reset
- exmem_regwrite  in  1  EX/MEM RegWrite (EXMEM bit 74)
- exmem_memwrite  in  1  EX/MEM MemWrite (bit 73); marks the current instruction as a store
- exmem_memtoreg  in  1  EX/MEM MemToReg (bit 72)
- exmem_reg  in  REG_W  EX/MEM register field (bits 68:64): destination for ALU ops and loads, source rt for stores
- exmem_alu  in  DATA_W  EX/MEM ALU result / memory address (bits 31:0)
- exmem_wdata  in  DATA_W  EX/MEM ReadData2, the un-forwarded store data (bits 63:32)
- mem_rdata  in  DATA_W  data-memory read data for the current EX/MEM instruction
- store_data  out  DATA_W  data to drive the data-memory write port
- fwd_sel  out  2  forwarding select: 00 none, 01 load data, 10 ALU result

## Operation
- **Shadow write-back register.** On every rising clk edge, capture:
  - wb_regwrite ← exmem_regwrite
  - wb_memtoreg ← exmem_memtoreg
  - wb_reg ← exmem_reg
  - wb_alu ← exmem_alu
  - wb_ldata ← mem_rdata
- **Forwarding decision** (combinational). Forwarding is active only when all of these hold:
  - exmem_memwrite = 1
  - wb_regwrite = 1
  - wb_reg ≠ 0
  - wb_reg = exmem_reg
- When forwarding is active:
  - wb_memtoreg = 1 → fwd_sel = 01
  - otherwise → fwd_sel = 10
- In all other cases, fwd_sel = 00.
- **Multiplexer** (combinational):
  - 00 → store_data = exmem_wdata
  - 01 → store_data = wb_ldata
  - 10 → store_data = wb_alu
  - 11 (unreachable) → store_data = exmem_wdata
- Register 0 is never forwarded, even when the previous instruction claims to write it.
- Non-store instructions always produce fwd_sel = 00. store_data still equals exmem_wdata but is ignored by memory.
- Only a one-instruction distance is covered. Older producers are handled by the register file / EX-stage forwarding and are out of scope.

## Timing
- Reset (rst_n low, asynchronous):
  - All shadow registers clear to 0.
  - Consequently fwd_sel = 00 and store_data = exmem_wdata immediately, without waiting for clk.
- Reset release takes effect at the next rising edge. No stale forwarding occurs on the first instruction after reset.
- Reset asserted mid-stream drops any pending forward at once. Forwarding resumes only after a producer has been captured post-reset.
- Latency:
  - fwd_sel and store_data are purely combinational from the EX/MEM inputs and the shadow registers; zero cycles.
  - The shadow registers update one cycle after the producer occupies EX/MEM.
  - Forwarding applies to the store in EX/MEM in the cycle immediately following the producer.
- mem_rdata must be valid before the clock edge that ends the producer's EX/MEM cycle. The data memory's read port is combinational.
- No handshakes. The block advances every cycle; no stall or enable input.

## Test plan
- **Reset.** Hold rst_n=0 with exmem_memwrite=1, exmem_reg=5'b11100, exmem_wdata=0x01010100 → fwd_sel=00, store_data=0x01010100.
- **Load→store.** Cycle N: lw, regwrite=1, memtoreg=1, reg=5'b11100, mem_rdata=0x01010100. Cycle N+1: sw, memwrite=1, reg=5'b11100, wdata=0x12345678 → fwd_sel=01, store_data=0x01010100.
- **ALU→store.** Cycle N: add, regwrite=1, memtoreg=0, reg=5'b11100, alu=0x08438433. Cycle N+1: sw to 0x19, reg=5'b11100, wdata=0x01354440 → fwd_sel=10, store_data=0x08438433.
- **No hazard.** Store follows a store (regwrite=0), or follows a write to a different register (5'b00011 vs 5'b11100) → fwd_sel=00, store_data=exmem_wdata.
- **Register 0.** Producer writes reg 0 with alu=0xDEADBEEF; next instruction is a store using reg 0 with wdata=0x0 → fwd_sel=00, store_data=0x0.
- **Non-store consumer.** lw to 5'b11100 followed by an add with reg=5'b11100 and memwrite=0 → fwd_sel=00.
